// File: rtl/issue_scoreboard.sv
// Issue scoreboard: reserves destination registers, stalls RAW/WAW hazards, caps in-flight count and traps on illegal ops.
// Optional macro SB_CPL_BYPASS_EN lets a same-cycle completion wake a stalled instruction with no bubble.
package issue_scoreboard_pkg;

  typedef struct packed {
    logic       valid;
    logic       predetermined;
    logic [4:0] rs;
  } reg_op_t;

  typedef struct packed {
    logic        illegal;
    logic [15:0] tag;
    reg_op_t     rd;
    reg_op_t     rs1;
    reg_op_t     rs2;
    reg_op_t     rs3;
  } instruction_pack_t;

  typedef struct packed {
    logic valid;
  } flush_t;

endpackage

module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  instruction_pack_t in_inst,
  input  logic              in_valid,
  output logic              in_ready,
  output instruction_pack_t out_inst,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cpl_valid,
  input  logic              cpl_wr,
  input  logic [4:0]        cpl_rd,
  input  flush_t            flush,
  output logic              trap_valid,
  output logic [31:0]       busy,
  output logic [3:0]        inflight
);

  typedef enum logic [2:0] {RUN, FLUSH, DRAIN, TRAP, HALT} state_e;

  localparam logic [3:0] MaxInflight = 4'(MAX_INFLIGHT);

  state_e            state_q, state_d;
  logic [31:0]       busy_q, busy_d;
  logic [3:0]        inflight_q, inflight_d;
  instruction_pack_t outInst_q, outInst_d;
  logic              outValid_q, outValid_d;

  logic              cplFire, dropFire;
  logic [31:0]       cplMask, dropMask, setMask;
  logic [31:0]       hazBusy;
  logic [3:0]        hazInflight;
  logic              hazard, accept, legalAccept, illegalAccept;
  logic [4:0]        incCount, decCount;

  function automatic logic srcHazard(input reg_op_t op, input logic [31:0] b);
    return op.valid & ~op.predetermined & b[op.rs];
  endfunction

  // A completion with nothing outstanding is ignored entirely; a flushed, unconsumed entry gives back its reservation.
  assign cplFire  = cpl_valid & (inflight_q != 4'd0);
  assign cplMask  = (cplFire && cpl_wr && cpl_rd != 5'd0) ? (32'd1 << cpl_rd) : 32'd0;
  assign dropFire = flush.valid & outValid_q & ~out_ready;
  assign dropMask = (dropFire && outInst_q.rd.valid && outInst_q.rd.rs != 5'd0)
                    ? (32'd1 << outInst_q.rd.rs) : 32'd0;

`ifdef SB_CPL_BYPASS_EN
  assign hazBusy     = busy_q & ~cplMask;
  assign hazInflight = inflight_q - {3'd0, cplFire};
`else
  assign hazBusy     = busy_q;
  assign hazInflight = inflight_q;
`endif

  assign hazard = srcHazard(in_inst.rs1, hazBusy) | srcHazard(in_inst.rs2, hazBusy) |
                  srcHazard(in_inst.rs3, hazBusy) | (in_inst.rd.valid & hazBusy[in_inst.rd.rs]);

  assign in_ready = (state_q == RUN) & ~flush.valid & ~hazard &
                    (~outValid_q | out_ready) & (hazInflight < MaxInflight);

  assign accept        = in_valid & in_ready;
  assign legalAccept   = accept & ~in_inst.illegal;
  assign illegalAccept = accept & in_inst.illegal;
  assign setMask       = (legalAccept && in_inst.rd.valid && in_inst.rd.rs != 5'd0)
                         ? (32'd1 << in_inst.rd.rs) : 32'd0;

  // Clears are applied before the new reservation so a same-register set wins.
  always_comb begin
    busy_d     = ((busy_q & ~cplMask & ~dropMask) | setMask) & ~32'd1;
    incCount   = {1'b0, inflight_q} + {4'd0, legalAccept};
    decCount   = {4'd0, cplFire} + {4'd0, dropFire};
    inflight_d = (incCount > decCount) ? 4'(incCount - decCount) : 4'd0;
  end

  always_comb begin
    outInst_d  = outInst_q;
    outValid_d = outValid_q;
    if (flush.valid) begin
      outValid_d = 1'b0;
    end else if (legalAccept) begin
      outInst_d  = in_inst;
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush.valid) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        RUN:     if (illegalAccept) state_d = DRAIN;
        FLUSH:   state_d = RUN;
        DRAIN:   if (inflight_q == 4'd0 && !outValid_q) state_d = TRAP;
        TRAP:    state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      busy_q     <= 32'd0;
      inflight_q <= 4'd0;
      outInst_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      outInst_q  <= outInst_d;
      outValid_q <= outValid_d;
    end
  end

  assign out_inst   = outInst_q;
  assign out_valid  = outValid_q;
  assign busy       = busy_q;
  assign inflight   = inflight_q;
  assign trap_valid = (state_q == TRAP);

endmodule
